// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bundle; master = fetch stage, slave = memory.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_valid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_valid, imem_rdata
  );
endinterface

// File: rtl/if_fetch_fsm.sv
// Fetch sequencer: owns the IDLE/REQ/WAIT/HOLD state, the drop flag and the imem handshake.
module if_fetch_fsm
  import if_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        PC_write,
  input  logic        IF_ID_write,
  input  logic        Flush,
  input  logic [31:0] pc_next_i,
  if_stage_if.master  imem,
  output logic        deliver_o,
  output logic        from_buf_o,
  output logic        buf_load_o
);

  fetch_state_e state_q, state_d;
  logic         drop_q, drop_d;
  logic [31:0]  addr_q;
  logic         hazard_free;
  fetch_state_e after_fetch;

  // addr_q follows the next PC except while a request waits for ready, which freezes the address.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      if (!(state_q == REQ && !imem.imem_ready)) begin
        addr_q <= pc_next_i;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    drop_d         = drop_q;
    deliver_o      = 1'b0;
    from_buf_o     = 1'b0;
    buf_load_o     = 1'b0;
    imem.imem_req  = (state_q == REQ);
    imem.imem_addr = {addr_q[31:2], 2'b00};
    hazard_free    = PC_write && IF_ID_write;
    after_fetch    = start_i ? REQ : IDLE;

    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = REQ;
      end
      REQ: begin
        if (Flush) drop_d = 1'b1;
        if (imem.imem_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem.imem_valid) begin
          if (Flush || drop_q) begin
            drop_d  = 1'b0;
            state_d = after_fetch;
          end else if (hazard_free) begin
            deliver_o = 1'b1;
            state_d   = after_fetch;
          end else begin
            buf_load_o = 1'b1;
            state_d    = HOLD;
          end
        end else if (Flush) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (Flush) begin
          state_d = REQ;
        end else if (hazard_free) begin
          deliver_o  = 1'b1;
          from_buf_o = 1'b1;
          state_d    = after_fetch;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, one-entry hold buffer and IF/ID register around if_fetch_fsm.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage
  import if_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        PC_write,
  input  logic        IF_ID_write,
  input  logic        Flush,
  input  logic [31:0] Branch_target,
  if_stage_if.master  imem,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_instr,
  output logic        IF_ID_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        deliver, from_buf, buf_load;
  logic [31:0] fetched;

  if_fetch_fsm u_fetch_fsm (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .PC_write   (PC_write),
    .IF_ID_write(IF_ID_write),
    .Flush      (Flush),
    .pc_next_i  (pc_d),
    .imem       (imem),
    .deliver_o  (deliver),
    .from_buf_o (from_buf),
    .buf_load_o (buf_load)
  );

  always_comb begin
    fetched      = from_buf ? buf_q : imem.imem_rdata;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (Flush) begin
      pc_d         = Branch_target & ~32'd3;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (deliver) begin
      pc_d         = pc_q + PC_INC;
      ifid_pc_d    = pc_q;
      ifid_instr_d = fetched;
      ifid_valid_d = 1'b1;
    end else if (IF_ID_write) begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_q         <= RESET_PC;
      buf_q        <= '0;
      ifid_pc_q    <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      if (buf_load) buf_q <= imem.imem_rdata;
    end
  end

  assign IF_ID_pc    = ifid_pc_q;
  assign IF_ID_instr = ifid_instr_q;
  assign IF_ID_valid = ifid_valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!IF_ID_write && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (Flush && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage with a transaction-level reference model and a latency-programmable memory.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pcw   = 1'b1;
  logic        ifw   = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] tgt   = '0;
  logic [31:0] ifid_pc, ifid_instr;
  logic        ifid_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  if_stage_if bus ();

  if_stage dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .start_i      (start),
    .PC_write     (pcw),
    .IF_ID_write  (ifw),
    .Flush        (flush),
    .Branch_target(tgt),
    .imem         (bus),
    .IF_ID_pc     (ifid_pc),
    .IF_ID_instr  (ifid_instr),
    .IF_ID_valid  (ifid_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: request presented / in flight / word parked, plus PC and IF/ID contents.
  bit          m_req, m_wait, m_hold, m_drop, m_ival;
  logic [31:0] m_pc, m_addr, m_buf, m_ipc, m_iinstr, m_stall, m_flushc;

  // Memory: one outstanding access, response lat cycles after acceptance.
  bit          mem_busy;
  int unsigned mem_cnt, lat = 1, p_ready = 100;
  logic [31:0] mem_data;

  task automatic model_reset();
    m_req = 0; m_wait = 0; m_hold = 0; m_drop = 0; m_ival = 0;
    m_pc = '0; m_addr = '0; m_buf = '0; m_ipc = '0; m_iinstr = NOP_INSTR;
    m_stall = '0; m_flushc = '0;
  endtask

  task automatic model_step();
    bit          both, got, n_req, n_wait, n_hold, n_drop;
    logic [31:0] gdata, n_pc, n_buf;
    if (rst_n !== 1'b1) begin
      model_reset();
      return;
    end
    both = pcw && ifw; got = 0; gdata = '0;
    n_req = m_req; n_wait = m_wait; n_hold = m_hold; n_drop = m_drop; n_buf = m_buf;
    if (m_req) begin
      if (flush) n_drop = 1;
      if (bus.imem_ready) begin n_req = 0; n_wait = 1; end
    end else if (m_wait) begin
      if (bus.imem_valid) begin
        n_wait = 0;
        if (flush || m_drop) begin n_drop = 0; n_req = start; end
        else if (both) begin got = 1; gdata = bus.imem_rdata; n_req = start; end
        else begin n_hold = 1; n_buf = bus.imem_rdata; end
      end else if (flush) n_drop = 1;
    end else if (m_hold) begin
      if (flush) begin n_hold = 0; n_req = 1; end
      else if (both) begin got = 1; gdata = m_buf; n_hold = 0; n_req = start; end
    end else if (start) n_req = 1;

    n_pc = flush ? (tgt & ~32'd3) : (got ? m_pc + 32'd4 : m_pc);
    if (flush) begin m_iinstr = NOP_INSTR; m_ival = 0; end
    else if (got) begin m_ipc = m_pc; m_iinstr = gdata; m_ival = 1; end
    else if (ifw) begin m_iinstr = NOP_INSTR; m_ival = 0; end
    if (!ifw && m_stall != '1) m_stall++;
    if (flush && m_flushc != '1) m_flushc++;
    if (!m_req && n_req) m_addr = n_pc;
    m_req = n_req; m_wait = n_wait; m_hold = n_hold; m_drop = n_drop; m_buf = n_buf; m_pc = n_pc;
  endtask

  task automatic compare();
    check("imem_req", 32'(bus.imem_req), 32'(m_req));
    if (m_req) check("imem_addr", bus.imem_addr, m_addr);
    check("if_id_pc", ifid_pc, m_ipc);
    check("if_id_instr", ifid_instr, m_iinstr);
    check("if_id_valid", 32'(ifid_valid), 32'(m_ival));
`ifdef IF_PERF_CNT_EN
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flushc);
`endif
  endtask

  task automatic drive_mem();
    if (mem_busy && mem_cnt == 0) begin
      bus.imem_valid = 1'b1;
      bus.imem_rdata = mem_data;
    end else begin
      bus.imem_valid = 1'b0;
      bus.imem_rdata = $urandom;
      if (mem_busy) mem_cnt--;
    end
    bus.imem_ready = !mem_busy && ($urandom_range(99) < p_ready);
  endtask

  task automatic step();
    bit acc;
    @(posedge clk);
    acc = (rst_n === 1'b1) && m_req && bus.imem_ready;
    model_step();
    if (bus.imem_valid) mem_busy = 0;
    if (acc) begin mem_busy = 1; mem_cnt = lat - 1; mem_data = $urandom; end
    @(negedge clk);
    compare();
    drive_mem();
  endtask

  function automatic bit cond(input int what);
    case (what)
      0:       return m_wait && bus.imem_valid;
      1:       return m_wait && !bus.imem_valid;
      default: return m_req;
    endcase
  endfunction

  task automatic wait_for(input int what, input string tag);
    for (int i = 0; i < 30 && !cond(what); i++) step();
    check(tag, 32'(cond(what)), 32'd1);
  endtask

  initial begin
    int unsigned pcs[$];
    int unsigned cycs[$];
    logic [31:0] saved;

    bus.imem_ready = 1'b0;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = '0;
    model_reset();
    step();
    step();
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_pc", ifid_pc, 32'h0);
    check("rst_instr", ifid_instr, 32'h0000_0013);
    check("rst_valid", 32'(ifid_valid), 32'd0);

    // Zero-wait streaming: deliveries at pc 0,4,8 two cycles apart.
    rst_n = 1; start = 1; p_ready = 100; lat = 1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (ifid_valid === 1'b1) begin pcs.push_back(ifid_pc); cycs.push_back(c); end
    end
    check("thru_count", 32'(pcs.size() >= 3), 32'd1);
    if (pcs.size() >= 3) begin
      check("thru_pc0", pcs[0], 32'h0);
      check("thru_pc1", pcs[1], 32'h4);
      check("thru_pc2", pcs[2], 32'h8);
      check("thru_gap1", cycs[1] - cycs[0], 32'd2);
      check("thru_gap2", cycs[2] - cycs[1], 32'd2);
    end

    // Stall over the second response: word parks in the buffer, then issues with pc 4.
    rst_n = 0; step(); rst_n = 1;
    wait_for(0, "to_resp0");
    step();
    wait_for(0, "to_resp1");
    saved = bus.imem_rdata;
    pcw = 0; ifw = 0;
    repeat (3) step();
    check("held_valid", 32'(ifid_valid), 32'd0);
    pcw = 1; ifw = 1;
    step();
    check("hold_pc", ifid_pc, 32'h4);
    check("hold_instr", ifid_instr, saved);
    check("hold_valid", 32'(ifid_valid), 32'd1);

    // Flush while waiting: response dropped, next request at the redirect target.
    lat = 3;
    wait_for(1, "to_wait_flush");
    flush = 1; tgt = 32'h0000_0103;
    step();
    flush = 0;
    check("flush_valid", 32'(ifid_valid), 32'd0);
    check("flush_instr", ifid_instr, 32'h0000_0013);
    wait_for(2, "to_redirect");
    check("redirect_addr", bus.imem_addr, 32'h0000_0100);

    // Memory not ready for 5 cycles: address steady, bubbles in IF/ID.
    p_ready = 0; bus.imem_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("nrdy_req", 32'(bus.imem_req), 32'd1);
      check("nrdy_addr", bus.imem_addr, 32'h0000_0100);
      check("nrdy_valid", 32'(ifid_valid), 32'd0);
    end
    p_ready = 100;

    // Reset while waiting; the late response must be ignored.
    wait_for(1, "to_wait_rst");
    rst_n = 0;
    step();
    check("mid_rst_req", 32'(bus.imem_req), 32'd0);
    check("mid_rst_pc", ifid_pc, 32'h0);
    check("mid_rst_instr", ifid_instr, 32'h0000_0013);
    check("mid_rst_valid", 32'(ifid_valid), 32'd0);
    rst_n = 1;
    repeat (12) step();

`ifdef IF_PERF_CNT_EN
    rst_n = 0; step(); rst_n = 1;
    pcw = 0; ifw = 0;
    repeat (4) step();
    pcw = 1; ifw = 1; flush = 1; tgt = 32'h40;
    repeat (2) step();
    flush = 0;
    step();
    check("perf_stall", stall_cnt, 32'd4);
    check("perf_flush", flush_cnt, 32'd2);
`endif

    // Randomized traffic with hazards, flushes, start drops and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      bit stall;
      if (c % 250 == 0) begin
        p_ready = $urandom_range(2) == 0 ? 30 : ($urandom_range(1) == 0 ? 70 : 100);
        lat = $urandom_range(4, 1);
      end
      stall = $urandom_range(99) < 20;
      start = $urandom_range(99) < 92;
      pcw   = stall ? 1'($urandom_range(1)) : 1'b1;
      ifw   = stall ? 1'($urandom_range(1)) : 1'b1;
      flush = $urandom_range(99) < 6;
      tgt   = $urandom;
      rst_n = $urandom_range(999) >= 3;
      step();
    end
    rst_n = 1; flush = 0; pcw = 1; ifw = 1;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 clk_i  in  1  single clock; all state updates on rising edge.
REQ-002 rst_i  in  1  synchronous, active-low reset, sampled on rising clk_i.
REQ-003 start_i  in  1  fetch enable; low = no new memory requests.
REQ-004 PC_write  in  1  hazard unit; 0 = hold PC.
REQ-005 IF_ID_write  in  1  hazard unit; 0 = hold IF/ID register.
REQ-006 Flush  in  1  branch taken, resolved in ID.
REQ-007 Branch_target  in  32  redirect PC, used when Flush=1.
REQ-008 imem_req  out  1  instruction-memory request valid.
REQ-009 imem_addr  out  32  request address, word aligned.
REQ-010 imem_ready  in  1  request accepted this cycle when imem_req=1.
REQ-011 imem_valid / imem_rdata  in  1 / 32  response strobe and instruction word.
REQ-012 IF_ID_pc / IF_ID_instr / IF_ID_valid  out  32 / 32 / 1  IF/ID register contents.
REQ-013 stall_cnt / flush_cnt  out  32 / 32  performance counters; present only per REQ-030.

Function
REQ-014 States: IDLE, REQ, WAIT, HOLD; at most one request outstanding.
REQ-015 IDLE: imem_req=0; go to REQ when start_i=1.
REQ-016 REQ: imem_req=1, imem_addr=PC; hold address stable until imem_ready=1, then go to WAIT.
REQ-017 WAIT: on imem_valid, if PC_write=1 and IF_ID_write=1, load IF/ID with {PC, rdata, valid=1}, PC<=PC+4, go to REQ (IDLE if start_i=0); otherwise store rdata in a 1-entry buffer and go to HOLD.
REQ-018 HOLD: no request; when PC_write=1 and IF_ID_write=1, load IF/ID from the buffer, PC<=PC+4, then go to REQ/IDLE as in REQ-017.
REQ-019 When IF_ID_write=1 and no instruction is delivered this cycle, IF/ID loads a bubble: valid=0, instr=32'h00000013, pc unchanged.
REQ-020 When IF_ID_write=0 and Flush=0, IF/ID holds all fields.
REQ-021 Flush has priority over stalls: IF/ID loads a bubble, PC<=Branch_target, and the HOLD buffer is discarded with a transition to REQ.
REQ-022 Flush in REQ or WAIT sets a drop flag: the in-flight request completes normally, its response is discarded, and the next request uses the redirected PC.
REQ-023 Flush coincident with imem_valid: the response is dropped and PC<=Branch_target.
REQ-024 A second Flush while the drop flag is set updates PC only; exactly one response is dropped.
REQ-025 start_i deasserted mid-transaction: the outstanding response completes per REQ-017; no new request is issued.
REQ-026 PC arithmetic wraps modulo 2^32; imem_addr[1:0] is always 2'b00 (Branch_target[1:0] ignored).
REQ-027 Best-case throughput with a zero-wait memory is one instruction per 2 cycles (request cycle, then response cycle).

Reset
REQ-028 When rst_i=0 at a clock edge: state=IDLE, PC=0, drop flag=0, buffer empty, IF_ID_pc=0, IF_ID_instr=32'h00000013, IF_ID_valid=0, imem_req=0.
REQ-029 Reset mid-transaction abandons the outstanding request; a response arriving after reset release while in IDLE is ignored.

Configuration
REQ-030 IF_PERF_CNT_EN: when defined, stall_cnt increments on every cycle with IF_ID_write=0, flush_cnt increments on every cycle with Flush=1, both saturate at 32'hFFFFFFFF, and both reset to 0; when undefined, both ports are absent and no counter logic exists.

Structure
REQ-031 The shared package holds the state enumeration, the NOP constant 32'h00000013, the reset PC 32'h0, and the PC increment 4.
REQ-032 One sub-module, if_fetch_fsm, owns the state, drop flag, and imem handshake; the PC, buffer, and IF/ID register sit in the top level.

Verification
REQ-033 Zero-wait memory (ready=1, valid one cycle after acceptance), no hazards -> IF_ID_valid pulses with pc 0, 4, 8, each valid every 2nd cycle.
REQ-034 IF_ID_write=0 and PC_write=0 for 3 cycles while imem_valid arrives -> FSM enters HOLD, IF/ID is held, and after release IF/ID={4, buffered word}.
REQ-035 Flush=1 with Branch_target=0x100 while in WAIT -> the next response is dropped, the next imem_addr is 0x100, and IF/ID shows a bubble.
REQ-036 imem_ready held low for 5 cycles -> imem_addr remains stable and IF/ID shows bubbles throughout.
REQ-037 rst_i=0 asserted in WAIT -> all reset values of REQ-028 hold at the next edge, and a late imem_valid is ignored.
REQ-038 With IF_PERF_CNT_EN, 4 stall cycles and 2 flushes -> stall_cnt=4 and flush_cnt=2.
